// File: rtl/ifetch_mem_port_pkg.sv
// ifetch_mem_port_pkg: shared widths, NOP encoding and fetch FSM states
package ifetch_mem_port_pkg;
  localparam int instruction_address_size = 32;
  localparam int instruction_size = 32;
  localparam logic [31:0] nop_inst = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
endpackage

// File: rtl/ifetch_mem_port_if.sv
// ifetch_mem_port_if: i-cache fetch request/response plus byte-wide RAM port
interface ifetch_mem_port_if import ifetch_mem_port_pkg::*; #(
  parameter int ADDR_W = instruction_address_size,
  parameter int INST_W = instruction_size
);
  logic instruction_read_flag;
  logic [ADDR_W-1:0] instruction_read_address;
  logic instruction_flag;
  logic [INST_W-1:0] instruction;
  logic running;
  logic [7:0] mem_din;
  logic [ADDR_W-1:0] mem_a;
  logic mem_wr;
  modport slave (
    input  instruction_read_flag, instruction_read_address, running, mem_din,
    output instruction_flag, instruction, mem_a, mem_wr
  );
  modport master (
    output instruction_read_flag, instruction_read_address, running, mem_din,
    input  instruction_flag, instruction, mem_a, mem_wr
  );
endinterface

// File: rtl/ifetch_byte_asm.sv
// ifetch_byte_asm: four little-endian byte slots, with the byte being captured forwarded into word_nxt
module ifetch_byte_asm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        cap,
  input  logic [1:0]  cap_idx,
  input  logic [7:0]  din,
  output logic [31:0] word_nxt
);
  logic [3:0][7:0] slot;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) slot <= '0;
    else if (clr) slot <= '0;
    else if (cap) slot[cap_idx] <= din;
  always_comb begin
    word_nxt = slot;
    if (cap) word_nxt[{cap_idx, 3'b000} +: 8] = din;
  end
endmodule

// File: rtl/ifetch_mem_port.sv
// ifetch_mem_port: fetch responder assembling a 32-bit LE word from four byte reads; IFETCH_ALIGN_CHECK_EN answers misaligned requests with NOP_INST
module ifetch_mem_port import ifetch_mem_port_pkg::*; #(
  parameter int ADDR_W = instruction_address_size,
  parameter int INST_W = instruction_size
`ifdef IFETCH_ALIGN_CHECK_EN
  , parameter logic [INST_W-1:0] NOP_INST = nop_inst
`endif
) (
  input logic clk,
  input logic rst_n,
  ifetch_mem_port_if.slave bus
);
  state_t state, state_nxt;
  logic [ADDR_W-1:0] base;
  logic [2:0] idx;
  logic [1:0] pend_idx, cap_idx;
  logic pend_v, cap_v, start, misaligned, abort, issue, cap, done;
  logic [31:0] word_nxt;
  assign bus.mem_wr = 1'b0;
  always_comb begin
`ifdef IFETCH_ALIGN_CHECK_EN
    misaligned = bus.instruction_read_address[1:0] != 2'b00;
`else
    misaligned = 1'b0;
`endif
    start = state == IDLE && bus.instruction_read_flag && bus.running;
    abort = state == FETCH && (!bus.instruction_read_flag || bus.instruction_read_address != base);
    cap = cap_v && !abort;
    done = cap && cap_idx == 2'd3;
    issue = state == FETCH && !abort && bus.running && idx < 3'd4;
    state_nxt = (state == DONE || abort) ? IDLE :
                start ? (misaligned ? DONE : FETCH) :
                done ? DONE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // pend tags the address now on mem_a; cap tags the byte now on mem_din
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      base <= '0;
      idx <= '0;
      pend_v <= 1'b0;
      pend_idx <= '0;
      cap_v <= 1'b0;
      cap_idx <= '0;
      bus.mem_a <= '0;
      bus.instruction_flag <= 1'b0;
      bus.instruction <= '0;
    end else begin
      pend_v <= (start && !misaligned) || issue;
      pend_idx <= start ? 2'd0 : idx[1:0];
      cap_v <= pend_v && !abort;
      cap_idx <= pend_idx;
      if (start && !misaligned) begin
        base <= bus.instruction_read_address;
        bus.mem_a <= bus.instruction_read_address;
        idx <= 3'd1;
      end else if (issue) begin
        bus.mem_a <= base + ADDR_W'(idx);
        idx <= idx + 3'd1;
      end
      bus.instruction_flag <= done || (start && misaligned);
`ifdef IFETCH_ALIGN_CHECK_EN
      bus.instruction <= done ? word_nxt[INST_W-1:0] : (start && misaligned) ? NOP_INST : '0;
`else
      bus.instruction <= done ? word_nxt[INST_W-1:0] : '0;
`endif
    end
  ifetch_byte_asm u_asm (
    .clk(clk),
    .rst_n(rst_n),
    .clr(state == IDLE || abort),
    .cap(cap),
    .cap_idx(cap_idx),
    .din(bus.mem_din),
    .word_nxt(word_nxt)
  );
endmodule

// File: tb/tb_ifetch_mem_port.sv
// tb_ifetch_mem_port: directed vector table, reset/alignment sequences and randomized traffic against a fetch model
module tb_ifetch_mem_port;
  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        run;
    logic        flag;
    logic [31:0] inst;
    logic [31:0] mem_a;
  } vec_t;
`ifdef IFETCH_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] ram [logic [31:0]];
  vec_t tbl[$];
  ifetch_mem_port_if bus();
  ifetch_mem_port dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [7:0] rr(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : (8'(a[7:0] * 8'd29) ^ a[15:8]);
  endfunction
  function automatic logic [31:0] word_at(input logic [31:0] b);
    return {rr(b + 32'd3), rr(b + 32'd2), rr(b + 32'd1), rr(b)};
  endfunction
  always @(posedge clk) bus.mem_din <= rr(bus.mem_a);
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic req, input logic [31:0] addr, input logic run);
    bus.instruction_read_flag = req;
    bus.instruction_read_address = addr;
    bus.running = run;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic add(input logic req, input logic [31:0] addr, input logic run,
                     input logic flag, input logic [31:0] inst, input logic [31:0] mem_a);
    tbl.push_back('{req, addr, run, flag, inst, mem_a});
  endtask
  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(3) == 0) a = 32'hffff_fffc | 32'($urandom_range(3));
    else if ($urandom_range(3) != 0) a[1:0] = 2'b00;
    return a;
  endfunction
  initial begin
    int w, ph, iss, last;
    logic req, run, ef;
    logic [31:0] addr, mb, ema, ei, w300;
    ram[32'h100] = 8'h13;
    ram[32'h101] = 8'h05;
    ram[32'h102] = 8'h00;
    ram[32'h103] = 8'h00;
    w300 = word_at(32'h300);
    // unstalled fetch of 0x100
    add(1, 32'h100, 1, 0, 0, 32'h100);
    add(1, 32'h100, 1, 0, 0, 32'h101);
    add(1, 32'h100, 1, 0, 0, 32'h102);
    add(1, 32'h100, 1, 0, 0, 32'h103);
    add(1, 32'h100, 1, 0, 0, 32'h103);
    add(1, 32'h100, 1, 1, 32'h0000_0513, 32'h103);
    add(0, 32'h100, 1, 0, 0, 32'h103);
    // three-cycle stall after the second address
    add(1, 32'h100, 1, 0, 0, 32'h100);
    add(1, 32'h100, 1, 0, 0, 32'h101);
    add(1, 32'h100, 0, 0, 0, 32'h101);
    add(1, 32'h100, 0, 0, 0, 32'h101);
    add(1, 32'h100, 0, 0, 0, 32'h101);
    add(1, 32'h100, 1, 0, 0, 32'h102);
    add(1, 32'h100, 1, 0, 0, 32'h103);
    add(1, 32'h100, 1, 0, 0, 32'h103);
    add(1, 32'h100, 1, 1, 32'h0000_0513, 32'h103);
    add(0, 32'h100, 1, 0, 0, 32'h103);
    // address changes 0x200 -> 0x300 mid-fetch
    add(1, 32'h200, 1, 0, 0, 32'h200);
    add(1, 32'h200, 1, 0, 0, 32'h201);
    add(1, 32'h300, 1, 0, 0, 32'h201);
    add(1, 32'h300, 1, 0, 0, 32'h300);
    add(1, 32'h300, 1, 0, 0, 32'h301);
    add(1, 32'h300, 1, 0, 0, 32'h302);
    add(1, 32'h300, 1, 0, 0, 32'h303);
    add(1, 32'h300, 1, 0, 0, 32'h303);
    add(1, 32'h300, 1, 1, w300, 32'h303);
    add(0, 32'h300, 1, 0, 0, 32'h303);
    // withdrawal on the byte-3 capture edge, then a clean refetch
    add(1, 32'h100, 1, 0, 0, 32'h100);
    add(1, 32'h100, 1, 0, 0, 32'h101);
    add(1, 32'h100, 1, 0, 0, 32'h102);
    add(1, 32'h100, 1, 0, 0, 32'h103);
    add(1, 32'h100, 1, 0, 0, 32'h103);
    add(0, 32'h100, 1, 0, 0, 32'h103);
    add(1, 32'h100, 1, 0, 0, 32'h100);
    add(1, 32'h100, 1, 0, 0, 32'h101);
    add(1, 32'h100, 1, 0, 0, 32'h102);
    add(1, 32'h100, 1, 0, 0, 32'h103);
    add(1, 32'h100, 1, 0, 0, 32'h103);
    add(1, 32'h100, 1, 1, 32'h0000_0513, 32'h103);
    add(0, 32'h100, 1, 0, 0, 32'h103);
    drive(0, 0, 0);
    #12;
    chk("reset_flag", 32'(bus.instruction_flag), 0);
    chk("reset_inst", bus.instruction, 0);
    chk("reset_mem_a", bus.mem_a, 0);
    chk("reset_mem_wr", 32'(bus.mem_wr), 0);
    rst_n = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].req, tbl[i].addr, tbl[i].run);
      tick();
      chk($sformatf("tbl%0d_flag", i), 32'(bus.instruction_flag), 32'(tbl[i].flag));
      chk($sformatf("tbl%0d_inst", i), bus.instruction, tbl[i].inst);
      chk($sformatf("tbl%0d_mem_a", i), bus.mem_a, tbl[i].mem_a);
    end
    // asynchronous reset in the middle of a fetch
    drive(1, 32'h100, 1);
    tick();
    tick();
    tick();
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_mem_a", bus.mem_a, 0);
    chk("async_rst_flag", 32'(bus.instruction_flag), 0);
    chk("async_rst_inst", bus.instruction, 0);
    #2 rst_n = 1'b1;
    w = 0;
    do begin
      tick();
      w++;
    end while (!bus.instruction_flag && w < 20);
    chk("restart_latency", 32'(w), 6);
    chk("restart_word", bus.instruction, 32'h0000_0513);
    drive(0, 0, 1);
    tick();
    chk("restart_pulse_end", 32'(bus.instruction_flag), 0);
    // misaligned request from a freshly reset port
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    drive(1, 32'h102, 1);
`ifdef IFETCH_ALIGN_CHECK_EN
    tick();
    chk("align_flag", 32'(bus.instruction_flag), 1);
    chk("align_nop", bus.instruction, 32'h0000_0013);
    chk("align_mem_a", bus.mem_a, 0);
    drive(0, 0, 1);
    tick();
    chk("align_pulse_end", 32'(bus.instruction_flag), 0);
`else
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("unaligned%0d_mem_a", k), bus.mem_a, 32'h102 + 32'(k < 3 ? k : 3));
      chk($sformatf("unaligned%0d_flag", k), 32'(bus.instruction_flag), 32'(k == 5));
    end
    chk("unaligned_word", bus.instruction, word_at(32'h102));
    drive(0, 0, 1);
    tick();
`endif
    // randomized traffic against a per-request timing model
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    ph = 0;
    iss = 0;
    last = 0;
    mb = 0;
    ema = 0;
    req = 0;
    addr = 0;
    for (int n = 0; n < 3000; n++) begin
      run = $urandom_range(3) != 0;
      drive(req, addr, run);
      ef = 1'b0;
      ei = 0;
      if (ph == 2) ph = 0;
      else if (ph == 1) begin
        if (!req || addr != mb) ph = 0;
        else if (iss == 4 && n == last + 2) begin
          ef = 1'b1;
          ei = word_at(mb);
          ph = 2;
        end else if (run && iss < 4) begin
          ema = mb + 32'(iss);
          iss++;
          last = n;
        end
      end else if (req && run) begin
        if (ALIGN && addr[1:0] != 2'b00) begin
          ef = 1'b1;
          ei = 32'h0000_0013;
          ph = 2;
        end else begin
          ph = 1;
          mb = addr;
          ema = addr;
          iss = 1;
          last = n;
        end
      end
      tick();
      chk("rnd_flag", 32'(bus.instruction_flag), 32'(ef));
      chk("rnd_inst", bus.instruction, ei);
      chk("rnd_mem_a", bus.mem_a, ema);
      if (ef) begin
        req = 1'($urandom_range(1));
        addr = rnd_addr();
      end else if (!req) begin
        if ($urandom_range(2) == 0) begin
          req = 1'b1;
          addr = rnd_addr();
        end
      end else if ($urandom_range(24) == 0) begin
        if ($urandom_range(1) == 1) req = 1'b0;
        else addr = rnd_addr();
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ifetch_mem_port.md
Name: ifetch_mem_port

Overview:
Memory-controller side of the instruction-fetch path. It is the responder to the i-cache read request (instruction_read_flag / instruction_read_address) and returns instruction_flag / instruction.
- Assembles one 32-bit little-endian instruction from the byte-wide RAM port using four sequential byte reads.
- Honours the global `running` stall.
- Aborts cleanly on request withdrawal, e.g. branch flush.

Parameters:
ADDR_W, 32, instruction address width (matches `Instruction_Address_size`)
INST_W, 32, instruction width (matches `Instruction_size`)
NOP_INST, 32'h00000013, word returned for rejected fetches (optional feature only)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
instruction_read_flag  in  1  fetch request from i-cache, level, held until served or withdrawn
instruction_read_address  in  ADDR_W  fetch address
instruction_flag  out  1  one-cycle pulse: instruction valid
instruction  out  INST_W  fetched word, valid only while instruction_flag=1
running  in  1  0 = global stall, no new RAM address issued
mem_din  in  8  RAM read byte, valid one cycle after its address
mem_a  out  ADDR_W  RAM byte address
mem_wr  out  1  RAM write enable, tied 0 (read-only port)

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; instruction_flag=0; instruction=0; mem_a=0; mem_wr=0; byte buffer=0; issue counter=0; pending-capture valid=0.
- State machine: IDLE, FETCH, DONE.
- IDLE:
  - On an edge with instruction_read_flag=1 and running=1: latch base=address; mem_a<=base; issue index<=1; pending<=(valid, idx 0); go to FETCH.
  - With running=0: stay in IDLE.
- FETCH issue:
  - Each edge with running=1 and issue index<4: mem_a<=base+index; index++; pending<=(valid, index).
  - With running=0, or once all four bytes are issued: mem_a holds and pending<=invalid.
- FETCH capture: each edge where pending was valid, store mem_din into byte slot pending.idx. This happens regardless of running, because the RAM already returned the byte.
- Word assembly: instruction[8k+7:8k] = byte k (little-endian). Byte addresses wrap modulo 2^ADDR_W.
- When byte 3 is captured: instruction<=assembled word; instruction_flag<=1; go to DONE.
- Unstalled latency: request sampled at edge E0; bytes captured at E2..E5; instruction_flag high in the cycle after E5 (6 cycles).
- DONE: lasts exactly one cycle with flag high. Next edge: flag<=0, instruction<=0, go to IDLE. The request is not sampled in DONE; the requester drops or changes address at that edge.
- Abort: in FETCH, if instruction_read_flag=0 or instruction_read_address≠base at an edge, go to IDLE. Pending and buffer are cleared, no flag is produced, and a new request is sampled the following edge.
- Abort has priority over the byte-3 completion in the same edge.
- Stall mid-fetch: bytes already issued are still captured; issue resumes from the next index when running returns; the word is assembled correctly.
- instruction_flag is never asserted unless all four bytes of the current base were captured after its latch.

Optional Feature:
Macro IFETCH_ALIGN_CHECK_EN.
- Defined: in IDLE, a request with address[1:0]≠0 issues no RAM reads. Next edge: instruction<=NOP_INST, instruction_flag<=1, go to DONE.
- Undefined: no alignment check; the four bytes are fetched from the unaligned base as given.

Decomposition:
- Shared defines file: `Instruction_Address_size`, `Instruction_size`, the NOP encoding, and the state encodings IDLE/FETCH/DONE.
- Sub-module ifetch_byte_asm is natural: 4-byte shift/slot buffer with capture-index input and assembled-word output.
- The FSM and issue counter stay in ifetch_mem_port.

Test Plan:
- RAM[0x100..0x103]=13,05,00,00; request 0x100, running=1 → mem_a 0x100..0x103 in consecutive cycles; flag pulse 1 cycle at 6 cycles after sampling; instruction=0x00000513.
- Same fetch with running=0 for 3 cycles after the second address → mem_a holds 0x101 during the stall; flag delayed by 3 cycles; word still 0x00000513.
- Request 0x200, then the address changes to 0x300 after 2 cycles → no flag for 0x200; mem_a restarts at 0x300; correct word for 0x300 returned.
- Request dropped mid-fetch in the same edge byte 3 would be captured → no flag; IDLE next cycle.
- rst_n pulsed low asynchronously mid-FETCH → all outputs 0 immediately; the next request starts cleanly.
- IFETCH_ALIGN_CHECK_EN defined, request 0x102 → no mem_a change; flag next cycle with instruction=0x00000013. Undefined → bytes read from 0x102..0x105.
